// File: rtl/inst_encoder_loader.sv
// Packs decoded instruction fields into 32-bit words and streams them, with
// sequential addresses, to an instruction-memory write port through a small FIFO.
module inst_encoder_loader #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [11:0]       in_ctrl,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_shift,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        err_count,
  output logic [ADDR_W:0]   inst_count
);

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam int                PTR_W   = $clog2(FIFO_DEPTH);
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_e;

  function automatic logic [31:0] encode(
    input logic [11:0] ctrl,
    input logic [4:0]  rd,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  sh,
    input logic [31:0] imm
  );
    if (ctrl[11:6] == 6'd0) begin
      return {6'd0, rd, rs, rt, sh, ctrl[5:0]};
    end
    return {ctrl[11:6], rd, rs, imm[15:0]};
  endfunction

  // I-type sets must carry a zero FUNC and an immediate that fits in 16 signed bits.
  function automatic logic is_legal(input logic [11:0] ctrl, input logic [31:0] imm);
    if (ctrl[11:6] == 6'd0) begin
      return 1'b1;
    end
    return (ctrl[5:0] == 6'd0) && (imm[31:16] == {16{imm[15]}});
  endfunction

  state_e            state_q, state_d;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [CNT_W-1:0]  count_q, count_d, remain;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_inst_q, out_inst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   inst_cnt_q, inst_cnt_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              err_q, err_d;

  logic        accept, legal, push, pop;
  logic [31:0] enc_word;

  assign enc_word = encode(in_ctrl, in_rd, in_rs, in_rt, in_shift, in_imm);
  assign legal    = is_legal(in_ctrl, in_imm);
  assign in_ready = (state_q == S_LOAD) && (count_q < DEPTH_C);
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal;
  assign pop      = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  if (accept && in_last) state_d = S_DRAIN;
      S_DRAIN: if ((count_q == '0) && !out_valid_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // count_q includes the head entry; the head register only reloads from
  // entries written on an earlier edge, which gives the one-cycle latency.
  always_comb begin
    rd_ptr_nxt  = rd_ptr_q + PTR_W'(pop);
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    remain      = count_q - CNT_W'(pop);
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    if (!out_valid_q || pop) begin
      out_valid_d = (remain != '0);
      if (remain != '0) begin
        out_inst_d = mem_q[rd_ptr_nxt];
      end
    end
  end

  always_comb begin
    addr_d     = addr_q;
    inst_cnt_d = inst_cnt_q;
    err_cnt_d  = err_cnt_q;
    err_d      = accept && !legal;
    if ((state_q == S_IDLE) && start) begin
      addr_d     = BASE;
      inst_cnt_d = '0;
      err_cnt_d  = '0;
    end else begin
      if (pop) begin
        addr_d     = addr_q + ADDR_W'(1);
        inst_cnt_d = inst_cnt_q + (ADDR_W + 1)'(1);
      end
      if (accept && !legal && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      addr_q      <= BASE;
      inst_cnt_q  <= '0;
      err_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_q + PTR_W'(push);
      rd_ptr_q    <= rd_ptr_nxt;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      addr_q      <= addr_d;
      inst_cnt_q  <= inst_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= enc_word;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_inst   = out_inst_q;
  assign out_addr   = addr_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign err_count  = err_cnt_q;
  assign inst_count = inst_cnt_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Bench for inst_encoder_loader: directed tables and sequences plus random traffic
// checked cycle by cycle against a queue-based model of the loader.
module tb_inst_encoder_loader;

  localparam int DEPTH = 4;
  localparam int P_IDLE = 0, P_LOAD = 1, P_DRAIN = 2, P_DONE = 3;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic        in_last = 1'b0, out_ready = 1'b0;
  logic [11:0] in_ctrl = '0;
  logic [4:0]  in_rd = '0, in_rs = '0, in_rt = '0, in_shift = '0;
  logic [31:0] in_imm = '0;

  logic        in_ready, out_valid, busy, done, err;
  logic [31:0] out_inst;
  logic [7:0]  out_addr, err_count;
  logic [8:0]  inst_count;
  logic        in_ready_b, out_valid_b, busy_b, done_b, err_b;
  logic [31:0] out_inst_b;
  logic [7:0]  out_addr_b, err_count_b;
  logic [8:0]  inst_count_b;

  inst_encoder_loader #(.ADDR_W(8), .FIFO_DEPTH(DEPTH), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_shift(in_shift),
    .in_imm(in_imm), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .busy(busy), .done(done), .err(err),
    .err_count(err_count), .inst_count(inst_count));

  inst_encoder_loader #(.ADDR_W(8), .FIFO_DEPTH(DEPTH), .BASE_ADDR(254)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_ctrl(in_ctrl), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_shift(in_shift),
    .in_imm(in_imm), .in_last(in_last), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_inst(out_inst_b), .out_addr(out_addr_b), .busy(busy_b), .done(done_b), .err(err_b),
    .err_count(err_count_b), .inst_count(inst_count_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] spec_enc(input logic [11:0] c, input logic [4:0] d,
      input logic [4:0] s, input logic [4:0] t, input logic [4:0] h, input logic [31:0] im);
    int unsigned opc, ud, us, ut, uh, w;
    opc = c / 64; ud = d; us = s; ut = t; uh = h;
    if (opc == 0) w = ud * (2**21) + us * (2**16) + ut * (2**11) + uh * 64 + (c % 64);
    else          w = opc * (2**26) + ud * (2**21) + us * (2**16) + (im % 65536);
    return w;
  endfunction

  function automatic bit spec_legal(input logic [11:0] c, input logic [31:0] im);
    int si;
    si = $signed(im);
    if (c / 64 == 0) return 1'b1;
    return (c % 64 == 0) && (si >= -32768) && (si <= 32767);
  endfunction

  typedef struct { logic [31:0] w; int e; } ent_t;
  typedef struct { logic [31:0] w; logic [7:0] a; } cap_t;
  ent_t mq[$];
  cap_t cap[$], cap2[$];
  int   m_phase = P_IDLE;
  logic [7:0] m_addr = '0, m_ecnt = '0, a2;
  logic [8:0] m_icnt = '0;
  bit   m_err = 0, exp_ov, exp_ir, drain_empty, done_seen = 0;
  int   n_acc = 0, n_errp = 0;

  // Reference model: words wait in a queue tagged with the edge that accepted
  // them and become visible one edge later, in order.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete(); m_phase = P_IDLE; m_addr = 0; m_icnt = 0; m_ecnt = 0;
        m_err = 0; done_seen = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_done", done, 0);
      end else begin
        exp_ov = (mq.size() > 0) && (mq[0].e <= cyc - 1);
        exp_ir = (m_phase == P_LOAD) && (mq.size() < DEPTH);
        chk("out_valid", out_valid, exp_ov);
        chk("out_valid_b", out_valid_b, exp_ov);
        chk("in_ready", in_ready, exp_ir);
        chk("busy", busy, m_phase != P_IDLE);
        chk("done", done, m_phase == P_DONE);
        chk("err", err, m_err);
        chk("err_count", err_count, m_ecnt);
        chk("inst_count", inst_count, m_icnt);
        chk("inst_count_b", inst_count_b, m_icnt);
        if (exp_ov) begin
          a2 = m_addr + 8'd254;
          chk("out_inst", out_inst, mq[0].w);
          chk("out_addr", out_addr, m_addr);
          chk("out_inst_b", out_inst_b, mq[0].w);
          chk("out_addr_b", out_addr_b, a2);
        end
        if (out_valid && out_ready) cap.push_back('{out_inst, out_addr});
        if (out_valid_b && out_ready) cap2.push_back('{out_inst_b, out_addr_b});
        if (in_valid && in_ready) n_acc++;
        if (err) n_errp++;
        if (done) done_seen = 1;
        m_err = 0;
        drain_empty = (mq.size() == 0);
        if (exp_ov && out_ready) begin
          void'(mq.pop_front());
          m_addr++;
          m_icnt++;
        end
        case (m_phase)
          P_IDLE: if (start) begin
            m_phase = P_LOAD; m_addr = 0; m_icnt = 0; m_ecnt = 0;
          end
          P_LOAD: if (in_valid && exp_ir) begin
            if (spec_legal(in_ctrl, in_imm))
              mq.push_back('{spec_enc(in_ctrl, in_rd, in_rs, in_rt, in_shift, in_imm), cyc + 1});
            else begin
              m_err = 1;
              if (m_ecnt != 8'd255) m_ecnt++;
            end
            if (in_last) m_phase = P_DRAIN;
          end
          P_DRAIN: if (drain_empty) m_phase = P_DONE;
          default: m_phase = P_IDLE;
        endcase
      end
    end
  end

  task automatic begin_session();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [11:0] c, input logic [4:0] d, input logic [4:0] s,
      input logic [4:0] t, input logic [4:0] h, input logic [31:0] im, input bit last);
    bit ok;
    ok = 0;
    in_valid = 1'b1; in_ctrl = c; in_rd = d; in_rs = s; in_rt = t; in_shift = h;
    in_imm = im; in_last = last;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("send_accepted", ok, 1);
  endtask

  task automatic wait_done(input string nm);
    bit got;
    got = 0;
    for (int k = 0; k < 600 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk(nm, got, 1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [11:0] c; logic [4:0] d, s, t, h; logic [31:0] im; bit ok; logic [31:0] w;
  } tvec_t;
  tvec_t tbl [10];
  logic [7:0]  wrap_exp [3];
  logic [15:0] rnd16;
  int j;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{12'h020, 5'd1,  5'd2,  5'd3,  5'd0,  32'h00000000, 1'b1, 32'h00221820};
    tbl[1] = '{12'h800, 5'd4,  5'd5,  5'd0,  5'd0,  32'hFFFFFFFC, 1'b1, 32'h8085FFFC};
    tbl[2] = '{12'h801, 5'd4,  5'd5,  5'd0,  5'd0,  32'h00000000, 1'b0, 32'h0};
    tbl[3] = '{12'hA00, 5'd1,  5'd1,  5'd0,  5'd0,  32'h00010000, 1'b0, 32'h0};
    tbl[4] = '{12'h000, 5'd31, 5'd0,  5'd7,  5'd5,  32'h00000000, 1'b1, 32'h03E03940};
    tbl[5] = '{12'h03F, 5'd0,  5'd31, 5'd31, 5'd31, 32'hDEADBEEF, 1'b1, 32'h001FFFFF};
    tbl[6] = '{12'hFC0, 5'd0,  5'd0,  5'd0,  5'd0,  32'h00007FFF, 1'b1, 32'hFC007FFF};
    tbl[7] = '{12'h040, 5'd1,  5'd1,  5'd0,  5'd0,  32'h00008000, 1'b0, 32'h0};
    tbl[8] = '{12'h040, 5'd2,  5'd3,  5'd31, 5'd31, 32'hFFFF8000, 1'b1, 32'h04438000};
    tbl[9] = '{12'h040, 5'd2,  5'd3,  5'd0,  5'd0,  32'hFFFF0000, 1'b0, 32'h0};
    wrap_exp[0] = 8'd254; wrap_exp[1] = 8'd255; wrap_exp[2] = 8'd0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_addr", out_addr, 8'd0);
    chk("rst_out_addr_b", out_addr_b, 8'd254);
    chk("rst_err_count", err_count, 0);
    chk("rst_inst_count", inst_count, 0);
    @(posedge clk); #1;

    // Table session: legal and illegal sets mixed, sink always ready.
    cap.delete(); out_ready = 1'b1;
    begin_session();
    for (int i = 0; i < 10; i++)
      send(tbl[i].c, tbl[i].d, tbl[i].s, tbl[i].t, tbl[i].h, tbl[i].im, i == 9);
    wait_done("tbl_done");
    chk("tbl_nwords", cap.size(), 6);
    j = 0;
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].ok) begin
        if (j < cap.size()) begin
          chk("tbl_word", cap[j].w, tbl[i].w);
          chk("tbl_addr", cap[j].a, j);
        end
        j++;
      end
    end
    chk("tbl_err_count", err_count, 4);
    chk("tbl_inst_count", inst_count, 6);

    // Only illegal sets: no words, two err pulses, session still completes.
    cap.delete(); n_errp = 0;
    begin_session();
    send(12'h801, 5'd1, 5'd2, 5'd0, 5'd0, 32'h0, 1'b0);
    send(12'hA00, 5'd1, 5'd2, 5'd0, 5'd0, 32'h00010000, 1'b1);
    wait_done("ill_done");
    chk("ill_nwords", cap.size(), 0);
    chk("ill_err_pulses", n_errp, 2);
    chk("ill_err_count", err_count, 2);

    // Backpressure: sink stalled while six sets are offered.
    cap.delete(); out_ready = 1'b0;
    begin_session();
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send({6'd0, 6'(i + 1)}, 5'(i), 5'(2 * i), 5'(31 - i), 5'(i), 32'h0, i == 5);
      end
      begin
        repeat (10) @(negedge clk);
        chk("bp_accepted", n_acc, 4);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_head", out_inst, spec_enc(12'h001, 5'd0, 5'd0, 5'd31, 5'd0, 32'h0));
        chk("bp_addr", out_addr, 0);
        repeat (3) @(negedge clk);
        chk("bp_head_hold", out_inst, spec_enc(12'h001, 5'd0, 5'd0, 5'd31, 5'd0, 32'h0));
        chk("bp_addr_hold", out_addr, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_done("bp_done");
    chk("bp_nwords", cap.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < cap.size()) begin
        chk("bp_word", cap[i].w, spec_enc({6'd0, 6'(i + 1)}, 5'(i), 5'(2 * i), 5'(31 - i), 5'(i), 32'h0));
        chk("bp_order_addr", cap[i].a, i);
      end
    end

    // Address wrap on the instance based at 254.
    cap2.delete(); out_ready = 1'b1;
    begin_session();
    for (int i = 0; i < 3; i++)
      send(12'h900, 5'(i), 5'd7, 5'd0, 5'd0, 32'(i), i == 2);
    wait_done("wrap_done");
    chk("wrap_nwords", cap2.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < cap2.size()) chk("wrap_addr", cap2[i].a, wrap_exp[i]);
    chk("wrap_inst_count", inst_count_b, 3);

    // Error counter saturation.
    begin_session();
    for (int i = 0; i < 260; i++)
      send(12'h801, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, i == 259);
    wait_done("sat_done");
    chk("sat_err_count", err_count, 255);

    // Reset while draining with two words queued.
    out_ready = 1'b0;
    begin_session();
    send(12'h020, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0, 1'b0);
    send(12'h020, 5'd4, 5'd5, 5'd6, 5'd0, 32'h0, 1'b1);
    @(posedge clk); #1;
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid_b", out_valid_b, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("no_done_after_rst", done_seen, 0);
    out_ready = 1'b1;
    begin_session();
    chk("restart_addr", out_addr, 0);
    chk("restart_inst_count", inst_count, 0);
    chk("restart_err_count", err_count, 0);
    chk("restart_busy", busy, 1);
    cap.delete();
    send(12'h800, 5'd4, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b1);
    wait_done("restart_done");
    chk("restart_word", (cap.size() == 1) ? cap[0].w : 32'hX, 32'h8085FFFC);
    chk("restart_final_count", inst_count, 1);

    // Random traffic, checked entirely by the model.
    for (int i = 0; i < 2500; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 1) in_ctrl = {6'd0, 6'($urandom)};
      else in_ctrl = {6'($urandom_range(1, 63)), ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'd0};
      rnd16 = 16'($urandom);
      in_imm = ($urandom_range(0, 9) < 7) ? {{16{rnd16[15]}}, rnd16} : 32'($urandom);
      in_rd = 5'($urandom); in_rs = 5'($urandom); in_rt = 5'($urandom); in_shift = 5'($urandom);
      in_last = ($urandom_range(0, 9) == 0);
      start = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; start = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
- Inverse of the instruction decoder: takes decoded fields (ctrl, rd, rs, rt, shift, imm) and packs them into a 32-bit instruction word.
- Streams encoded words, each paired with a sequential instruction-memory address, to the instruction-memory write port.
- Used by the program loader and the bench to build test programs.
- Contains a load/drain state machine, a small FIFO between encode and output, field legality checks, and counters.

Parameters:
ADDR_W, 8, instruction-memory address width
FIFO_DEPTH, 4, encoded-word FIFO entries (power of 2, >=2)
BASE_ADDR, 0, first address written after start

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a load session (honoured only in IDLE)
in_valid  in  1  field set valid
in_ready  out  1  field set accepted when in_valid&&in_ready
in_ctrl  in  12  {OPC[11:6], FUNC[5:0]}, decoder ctrl format
in_rd  in  5  destination
in_rs  in  5  source
in_rt  in  5  operand (R-type only)
in_shift  in  5  shift amount (R-type only)
in_imm  in  32  sign-extended immediate (I-type only)
in_last  in  1  marks final field set of session
out_valid  out  1  encoded word available
out_ready  in  1  sink accepts when out_valid&&out_ready
out_inst  out  32  encoded instruction
out_addr  out  ADDR_W  target memory address
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at session end
err  out  1  one-cycle pulse, illegal field set dropped
err_count  out  8  illegal sets this session, saturates at 255
inst_count  out  ADDR_W+1  words emitted this session

Behaviour:
- Reset (rst_n=0, async): state=IDLE, FIFO empty, in_ready=0, out_valid=0, out_inst=0, out_addr=BASE_ADDR, done=0, err=0, err_count=0, inst_count=0. Reset mid-session discards all FIFO contents with no further outputs.
- Encoding (combinational at acceptance, OPC=in_ctrl[11:6]):
  - R-type (OPC==0): {6'b0, rd, rs, rt, shift, in_ctrl[5:0]}.
  - I-type (OPC!=0): {OPC, rd, rs, in_imm[15:0]}; in_rt and in_shift ignored.
- Legality, I-type only; either violation is illegal:
  - in_ctrl[5:0] must be 0.
  - in_imm[31:16] must equal {16{in_imm[15]}}.
  - R-type sets are always legal; in_imm is ignored.
- Illegal set handling: accepted but not pushed. err=1 in the cycle after acceptance. err_count increments, saturating at 255.
- FSM:
  - IDLE: in_ready=0. start -> LOAD; same edge: out_addr=BASE_ADDR, err_count=0, inst_count=0.
  - LOAD: in_ready = (fifo_count < FIFO_DEPTH), decided on registered count only, so a full FIFO holds in_ready=0 even if popping this cycle. Acceptance with in_last=1 -> DRAIN, legal or not.
  - DRAIN: in_ready=0. FIFO empty and no output pending -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
  - start outside IDLE is ignored.
- Output side:
  - FIFO head is registered; a word accepted at edge N is visible on out_inst/out_valid after edge N+1 at earliest (latency 1 with empty FIFO).
  - out_valid = FIFO non-empty.
  - out_inst and out_addr hold stable while out_valid && !out_ready.
  - On out_valid&&out_ready: pop; out_addr+1 (wraps modulo 2^ADDR_W, no flag); inst_count+1 (wraps).
- Simultaneous push and pop: count unchanged, order preserved. Push into empty FIFO with pop in the same cycle is not possible (head registered).
- Back-to-back sustained throughput: one word per cycle when out_ready=1 continuously.

Test Plan:
- R-type: start; in_ctrl=12'h020, rd=1, rs=2, rt=3, shift=0, in_last=1, out_ready=1 -> out_inst=32'h00221820, out_addr=0, then done pulse; inst_count=1, err_count=0.
- I-type negative imm: in_ctrl=12'h800, rd=4, rs=5, in_imm=32'hFFFFFFFC -> out_inst=32'h8085FFFC.
- Illegal sets: in_ctrl=12'h801, then in_ctrl=12'hA00 with in_imm=32'h00010000 -> no output words, two err pulses, err_count=2; session still reaches done on in_last.
- Backpressure/full: out_ready=0, 6 legal sets offered -> in_ready drops after 4 accepted. Release out_ready -> addresses 0..5 in order, data in order, stable while stalled.
- Wrap: BASE_ADDR=254, ADDR_W=8, 3 words -> out_addr 254, 255, 0; inst_count=3.
- Reset mid-DRAIN with 2 words queued: rst_n low -> out_valid=0, busy=0 immediately. No done pulse. Next start begins at BASE_ADDR with counts 0.
